// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mult_div_pkg
// Shared definitions for the iterative multiply/divide unit.
//   md_op_e    : MDOp encodings (MULTU, MULT, DIVU, DIV)
//   md_state_e : controller states (IDLE, RUN, FIX)
//   cntWidth   : iteration counter width for a given operand width
//   isDivOp    : true for DIVU/DIV
//   isSignedOp : true for MULT/DIV
// ---------------------------------------------------------------------------
package mult_div_pkg;

  localparam int MD_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // One extra bit so the counter can represent WIDTH itself.
  function automatic int cntWidth(input int w);
    return $clog2(w) + 1;
  endfunction

  function automatic logic isDivOp(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic isSignedOp(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Operand / control / result bundle between the control unit and the
// multiply/divide unit.
//   master (control unit): drives Start, MDOp, A, B, WrHI, WrLO, WrData;
//                          observes Busy, Done, DivByZero, HI, LO
//   slave  (mult_div_unit): the reverse
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             Start;
  logic [1:0]       MDOp;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             WrHI;
  logic             WrLO;
  logic [WIDTH-1:0] WrData;
  logic             Busy;
  logic             Done;
  logic             DivByZero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, MDOp, A, B, WrHI, WrLO, WrData,
    input  Busy, Done, DivByZero, HI, LO
  );

  modport slave (
    input  Start, MDOp, A, B, WrHI, WrLO, WrData,
    output Busy, Done, DivByZero, HI, LO
  );

endinterface

// File: rtl/mult_div_unit_twos_fix.sv
// ---------------------------------------------------------------------------
// twos_fix
// Combinational conditional two's-complement negate.
//   i_mag : input value (magnitude)
//   i_neg : 1 = negate, 0 = pass through
//   o_val : result
// Used both to strip operand signs and to re-apply result signs.
// ---------------------------------------------------------------------------
module twos_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_mag,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_mag + W'(1)) : i_mag;

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative WIDTH-bit multiply/divide unit producing the MIPS HI/LO pair.
// Multiply is shift-add, divide is restoring shift-subtract; both run
// through the same remainder/quotient register pair for WIDTH cycles,
// followed by one sign-correction cycle.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : mult_div_unit_if slave modport
//           in : Start, MDOp, A, B, WrHI, WrLO, WrData
//           out: Busy, Done, DivByZero, HI, LO (all registered)
// ---------------------------------------------------------------------------
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam int CNT_W = cntWidth(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  md_state_e          r_state;
  md_state_e          w_nextState;
  md_op_e             r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_divZero;
  logic [WIDTH-1:0]   r_origA;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_busy;
  logic               r_done;
  logic               r_dz;

  md_op_e             w_inOp;
  logic               w_signedIn;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH+1:0]   w_shifted;
  logic [WIDTH:0]     w_trial;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_prodFixed;
  logic [WIDTH-1:0]   w_quoFixed;
  logic [WIDTH-1:0]   w_remFixed;

  assign w_inOp     = md_op_e'(bus.MDOp);
  assign w_signedIn = isSignedOp(w_inOp);

  // Operand magnitudes; unsigned ops pass straight through.
  twos_fix #(.W(WIDTH)) u_magA (
    .i_mag (bus.A),
    .i_neg (w_signedIn & bus.A[WIDTH-1]),
    .o_val (w_magA)
  );

  twos_fix #(.W(WIDTH)) u_magB (
    .i_mag (bus.B),
    .i_neg (w_signedIn & bus.B[WIDTH-1]),
    .o_val (w_magB)
  );

  // Multiply step: r_rem holds the upper accumulator half, r_quo the
  // lower half whose LSB is the current multiplier bit. The carry out of
  // the add lands in w_mulSum[WIDTH] and is shifted down next cycle.
  assign w_mulSum = {1'b0, r_rem[WIDTH-1:0]} +
                    {1'b0, (r_quo[0] ? r_mcand : {WIDTH{1'b0}})};

  // Divide step: shift the next dividend bit into the remainder and try
  // subtracting the divisor. The comparison is done on the full widened
  // value so the trial result never needs a borrow bit of its own.
  assign w_shifted = {r_rem, r_quo[WIDTH-1]};
  assign w_fits    = (w_shifted >= {2'b00, r_mcand});
  assign w_trial   = w_shifted[WIDTH:0] - {1'b0, r_mcand};

  // Result sign correction applied during FIX.
  twos_fix #(.W(2*WIDTH)) u_prodFix (
    .i_mag ({r_rem[WIDTH-1:0], r_quo}),
    .i_neg (r_negRes),
    .o_val (w_prodFixed)
  );

  twos_fix #(.W(WIDTH)) u_quoFix (
    .i_mag (r_quo),
    .i_neg (r_negRes),
    .o_val (w_quoFixed)
  );

  twos_fix #(.W(WIDTH)) u_remFix (
    .i_mag (r_rem[WIDTH-1:0]),
    .i_neg (r_negRem),
    .o_val (w_remFixed)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: RUN lasts exactly WIDTH cycles, FIX one.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.Start) w_nextState = RUN;
      RUN:     if (r_cnt == LAST_ITER) w_nextState = FIX;
      FIX:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath and registered outputs. HI/LO only change on MTHI/MTLO in a
  // quiet IDLE cycle or in FIX, so iteration state never leaks out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_op      <= MD_MULTU;
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
      r_origA   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_op      <= w_inOp;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_origA   <= bus.A;
            r_negRes  <= w_signedIn & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            r_negRem  <= w_signedIn & bus.A[WIDTH-1];
            r_divZero <= isDivOp(w_inOp) && (bus.B == '0);
            if (isDivOp(w_inOp)) begin
              r_quo   <= w_magA;
              r_mcand <= w_magB;
            end else begin
              r_quo   <= w_magB;
              r_mcand <= w_magA;
            end
          end else begin
            if (bus.WrHI) r_hi <= bus.WrData;
            if (bus.WrLO) r_lo <= bus.WrData;
          end
        end
        RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (isDivOp(r_op)) begin
            r_rem <= w_fits ? w_trial : w_shifted[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], w_fits};
          end else begin
            r_rem <= {1'b0, w_mulSum[WIDTH:1]};
            r_quo <= {w_mulSum[0], r_quo[WIDTH-1:1]};
          end
        end
        FIX: begin
          r_done <= 1'b1;
          r_dz   <= r_divZero;
          if (isDivOp(r_op)) begin
            if (r_divZero) begin
              r_lo <= '1;
              r_hi <= r_origA;
            end else begin
              r_lo <= w_quoFixed;
              r_hi <= w_remFixed;
            end
          end else begin
            {r_hi, r_lo} <= w_prodFixed;
          end
        end
        default: ;
      endcase
      r_busy <= (w_nextState != IDLE);
    end
  end

  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.DivByZero = r_dz;
  assign bus.HI        = r_hi;
  assign bus.LO        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Directed bench for mult_div_unit (WIDTH=32). Stimulus pushes expected
// HI/LO/DivByZero into a queue; a monitor pops and compares on each Done.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;
  import mult_div_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t expQ[$];

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the sequence.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Monitor: every Done pops one expectation; DivByZero must never be
  // high outside a Done cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && bus.Done) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done actual=1 expected=0");
        end else begin
          e = expQ.pop_front();
          checkOutput({e.name, "_HI"}, bus.HI, e.hi);
          checkOutput({e.name, "_LO"}, bus.LO, e.lo);
          checkOutput({e.name, "_DZ"}, {31'b0, bus.DivByZero}, {31'b0, e.dz});
          checkOutput({e.name, "_BUSY_AT_DONE"}, {31'b0, bus.Busy}, 32'd0);
        end
      end else if (reset) begin
        checkOutput("dz_outside_done", {31'b0, bus.DivByZero}, 32'd0);
      end
    end
  end

  // Issue one operation, push its expectation and measure latency/Busy.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expHi,
                               input logic [31:0] expLo, input logic expDz,
                               input string name);
    exp_t e;
    int   lat;
    int   busyCnt;
    e.hi = expHi; e.lo = expLo; e.dz = expDz; e.name = name;
    bus.MDOp  = op;
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    expQ.push_back(e);
    @(posedge clk); #1;
    bus.Start = 1'b0;
    lat = 0;
    busyCnt = 0;
    while (!bus.Done && lat < 100) begin
      if (bus.Busy) busyCnt++;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({name, "_LATENCY"}, lat, 32'd33);
    checkOutput({name, "_BUSY_CYCLES"}, busyCnt, 32'd33);
  endtask

  initial begin
    int doneCnt;
    int n;
    checks = 0;
    errors = 0;
    bus.Start  = 1'b0;
    bus.MDOp   = 2'b00;
    bus.A      = '0;
    bus.B      = '0;
    bus.WrHI   = 1'b0;
    bus.WrLO   = 1'b0;
    bus.WrData = '0;
    reset      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_BUSY", {31'b0, bus.Busy}, 32'd0);
    checkOutput("reset_DONE", {31'b0, bus.Done}, 32'd0);
    checkOutput("reset_DZ",   {31'b0, bus.DivByZero}, 32'd0);
    checkOutput("reset_HI",   bus.HI, 32'd0);
    checkOutput("reset_LO",   bus.LO, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    applyStimulus(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, "multu_full");
    applyStimulus(MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, "mult_neg");
    applyStimulus(MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, "divu");
    applyStimulus(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, "div_trunc");
    applyStimulus(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, "div_negb");
    applyStimulus(MD_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, "divu_zero");
    applyStimulus(MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, "div_zero");
    applyStimulus(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, "div_ovf");

    // Start and MTHI while busy must both be ignored; HI/LO keep the
    // previous result (0 / 0x80000000) until this multiply completes.
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd12; e.dz = 1'b0; e.name = "busy_ignore";
      bus.MDOp = MD_MULTU; bus.A = 32'd3; bus.B = 32'd4; bus.Start = 1'b1;
      expQ.push_back(e);
      @(posedge clk); #1;
      bus.Start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      bus.MDOp = MD_DIVU; bus.A = 32'd9; bus.B = 32'd3; bus.Start = 1'b1;
      bus.WrHI = 1'b1; bus.WrData = 32'h0000DEAD;
      @(posedge clk); #1;
      bus.Start = 1'b0; bus.WrHI = 1'b0;
      checkOutput("busy_mid_HI", bus.HI, 32'h00000000);
      checkOutput("busy_mid_LO", bus.LO, 32'h80000000);
      n = 0;
      while (!bus.Done && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      checkOutput("busy_ignore_done_seen", {31'b0, bus.Done}, 32'd1);
      repeat (40) @(posedge clk);
      #1;
      checkOutput("busy_ignore_idle_after", {31'b0, bus.Busy}, 32'd0);
    end

    // MTLO alone, then MTHI+MTLO together.
    bus.WrLO = 1'b1; bus.WrData = 32'h00001234;
    @(posedge clk); #1;
    bus.WrLO = 1'b0;
    checkOutput("mtlo_LO", bus.LO, 32'h00001234);
    checkOutput("mtlo_HI", bus.HI, 32'h00000000);
    bus.WrHI = 1'b1; bus.WrLO = 1'b1; bus.WrData = 32'hCAFEF00D;
    @(posedge clk); #1;
    bus.WrHI = 1'b0; bus.WrLO = 1'b0;
    checkOutput("mthilo_HI", bus.HI, 32'hCAFEF00D);
    checkOutput("mthilo_LO", bus.LO, 32'hCAFEF00D);

    // Reset during cycle 10 of a multiply aborts it with no Done.
    bus.MDOp = MD_MULTU; bus.A = 32'd5; bus.B = 32'd6; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_mid_BUSY", {31'b0, bus.Busy}, 32'd0);
    checkOutput("rst_mid_HI", bus.HI, 32'd0);
    checkOutput("rst_mid_LO", bus.LO, 32'd0);
    reset = 1'b1;
    doneCnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (bus.Done) doneCnt++;
    end
    checkOutput("rst_mid_no_done", doneCnt, 32'd0);

    applyStimulus(MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, "multu_after_rst");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
